wbu_queue: RTL

//  Parametrised write-back unit: takes LSU results, forms wb_data (CSR / load-extend / ALU) at enqueue,

---
 rtl/wbu_queue_pkg.sv | 37 +++
 rtl/wbu_queue_fifo.sv | 66 ++++++
 rtl/wbu_queue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wbu_queue_pkg.sv
// Shared types and constants for the write-back queue.
package wbu_queue_pkg;

  // Widest supported configuration; narrower builds zero-fill the upper bits.
  localparam int unsigned XLEN_MAX = 64;
  localparam int unsigned NCSR_MAX = 8;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

  typedef enum int unsigned {
    CSR_MSTATUS = 0,
    CSR_MTVEC   = 1,
    CSR_MEPC    = 2,
    CSR_MCAUSE  = 3
  } csr_ch_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0]          pc;
    logic [31:0]                  inst;
    logic                         reg_wen;
    logic [4:0]                   rd;
    logic [XLEN_MAX-1:0]          wb_data;
    logic [NCSR_MAX-1:0]          csr_wen;
    logic [NCSR_MAX*XLEN_MAX-1:0] csr_wdata;
  } wb_entry_t;

  localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wbu_queue_fifo.sv
// Generic circular FIFO with per-slot occupancy and flat storage view.
module wbu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          count,
  output logic [DEPTH*WIDTH-1:0] mem_o,
  output logic [DEPTH-1:0]       occ_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] vld_q;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (pop) begin
        head_q        <= ptr_next(head_q);
        vld_q[head_q] <= 1'b0;
      end
      // When full, tail==head: the push must win over the pop's clear.
      if (push) begin
        tail_q        <= ptr_next(tail_q);
        vld_q[tail_q] <= 1'b1;
      end
      if (push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    mem_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) mem_o[i*WIDTH +: WIDTH] = mem[i];
  end

  assign rdata = mem[head_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign occ_o = vld_q;

endmodule

// File: rtl/wbu_queue.sv
// Write-back queue: forms wb_data at enqueue, buffers in order, gates head outputs.
module wbu_queue
  import wbu_queue_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned NCSR  = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [31:0]          inst_i,
  input  logic [XLEN-1:0]      alu_out_i,
  input  logic                 reg_wen_i,
  input  logic [4:0]           rd_i,
  input  logic                 zicsr_i,
  input  logic [XLEN-1:0]      csr_rdata_i,
  input  logic                 mem_read_i,
  input  logic [2:0]           func3_i,
  input  logic [XLEN-1:0]      mem_rdata_i,
  input  logic [NCSR-1:0]      csr_wen_i,
  input  logic [NCSR*XLEN-1:0] csr_wdata_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      pc_o,
  output logic [31:0]          inst_o,
  output logic                 reg_wen_o,
  output logic [4:0]           rd_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic [NCSR-1:0]      csr_wen_o,
  output logic [NCSR*XLEN-1:0] csr_wdata_o,
  input  logic [4:0]           chk_rs1_i,
  input  logic [4:0]           chk_rs2_i,
  output logic                 raw_hit_o,
  output logic [CW-1:0]        count_o,
  output logic [63:0]          retired_o
);

  logic                          push, pop, full, empty;
  logic [WB_ENTRY_W-1:0]         enq_vec, head_vec;
  logic [DEPTH*WB_ENTRY_W-1:0]   mem_flat;
  logic [DEPTH-1:0]              occ;
  wb_entry_t                     enq, head, ent;
  logic [XLEN-1:0]               load_data;
  logic [63:0]                   retired_q;
  logic                          unused_ok;

  assign out_valid = !empty;
  assign in_ready  = !full || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    load_data = '0;
    case (load_f3_e'(func3_i))
      F3_LB:  load_data = XLEN'($signed(mem_rdata_i[7:0]));
      F3_LH:  load_data = XLEN'($signed(mem_rdata_i[15:0]));
      F3_LW:  load_data = XLEN'($signed(mem_rdata_i[31:0]));
      F3_LBU: load_data = XLEN'(mem_rdata_i[7:0]);
      F3_LHU: load_data = XLEN'(mem_rdata_i[15:0]);
      F3_LD:  if (XLEN == 64) load_data = mem_rdata_i;
      F3_LWU: if (XLEN == 64) load_data = XLEN'(mem_rdata_i[31:0]);
      default: load_data = '0;
    endcase
  end

  always_comb begin
    enq         = '0;
    enq.pc      = XLEN_MAX'(pc_i);
    enq.inst    = inst_i;
    enq.reg_wen = reg_wen_i && (rd_i != 5'd0);
    enq.rd      = rd_i;
    enq.wb_data = zicsr_i    ? XLEN_MAX'(csr_rdata_i) :
                  mem_read_i ? XLEN_MAX'(load_data)   :
                               XLEN_MAX'(alu_out_i);
    enq.csr_wen = NCSR_MAX'(csr_wen_i);
    for (int unsigned k = 0; k < NCSR; k++)
      enq.csr_wdata[k*XLEN_MAX +: XLEN_MAX] = XLEN_MAX'(csr_wdata_i[k*XLEN +: XLEN]);
  end

  assign enq_vec = enq;

  wbu_fifo #(
    .WIDTH (WB_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (enq_vec),
    .rdata (head_vec),
    .full  (full),
    .empty (empty),
    .count (count_o),
    .mem_o (mem_flat),
    .occ_o (occ)
  );

  always_comb begin
    head        = wb_entry_t'(head_vec);
    pc_o        = out_valid ? head.pc[XLEN-1:0]      : '0;
    inst_o      = out_valid ? head.inst              : '0;
    reg_wen_o   = out_valid && head.reg_wen;
    rd_o        = out_valid ? head.rd                : '0;
    wb_data_o   = out_valid ? head.wb_data[XLEN-1:0] : '0;
    csr_wen_o   = out_valid ? head.csr_wen[NCSR-1:0] : '0;
    csr_wdata_o = '0;
    for (int unsigned k = 0; k < NCSR; k++)
      if (out_valid) csr_wdata_o[k*XLEN +: XLEN] = head.csr_wdata[k*XLEN_MAX +: XLEN];
  end

  always_comb begin
    raw_hit_o = 1'b0;
    ent       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent = wb_entry_t'(mem_flat[i*WB_ENTRY_W +: WB_ENTRY_W]);
      if (occ[i] && ent.reg_wen && (ent.rd == chk_rs1_i || ent.rd == chk_rs2_i))
        raw_hit_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_q <= '0;
    else if (pop) retired_q <= retired_q + 64'd1;
  end

  assign retired_o = retired_q;
  assign unused_ok = ^{mem_flat, head_vec, ent};

endmodule
